// File: rtl/com_bus_arbiter_if.sv
// com_bus_arbiter_if
// Bundles the request/grant wiring between the cache controllers and the
// common-bus arbiter.
//   Com_Bus_Req_proc   proc-side requests, one per DL/IL controller (level)
//   Com_Bus_Req_snoop  snoop-side writeback/flush requests (level)
//   Mem_snoop_req      lower-level memory request on the snoop path (level)
//   Com_Bus_Gnt_proc   one-hot-or-zero proc grant
//   Com_Bus_Gnt_snoop  one-hot-or-zero snoop grant
//   Mem_snoop_gnt      memory snoop grant, never together with Com_Bus_Gnt_snoop
//   Bus_busy           a proc transaction owns or is releasing the bus
//   Arb_err            sticky hold-limit violation flag
// The master modport is the requester side; the slave modport is the arbiter.
interface com_bus_arbiter_if #(
  parameter int NUM_REQ = 8
);
  logic [NUM_REQ-1:0] Com_Bus_Req_proc;
  logic [NUM_REQ-1:0] Com_Bus_Req_snoop;
  logic               Mem_snoop_req;
  logic [NUM_REQ-1:0] Com_Bus_Gnt_proc;
  logic [NUM_REQ-1:0] Com_Bus_Gnt_snoop;
  logic               Mem_snoop_gnt;
  logic               Bus_busy;
  logic               Arb_err;

  modport master (
    output Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req,
    input  Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Mem_snoop_gnt, Bus_busy, Arb_err
  );

  modport slave (
    input  Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req,
    output Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Mem_snoop_gnt, Bus_busy, Arb_err
  );
endinterface

// File: rtl/com_bus_arbiter.sv
// com_bus_arbiter
// Common-bus arbiter for the 4-core MESI cache subsystem. Two grant domains
// run side by side:
//   proc domain  - round-robin over NUM_REQ processor-side requesters
//   snoop domain - fixed priority (lowest index first, memory last), only
//                  arbitrating while a proc transaction owns the bus
// A proc owner holding the bus for MAX_HOLD consecutive cycles sets the
// sticky Arb_err flag.
// Ports:
//   clk    clock, all state changes on posedge
//   rst_n  asynchronous active-low reset
//   bus    com_bus_arbiter_if.slave (requests in, registered grants out)
module com_bus_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int MAX_HOLD = 64,
  parameter int HOLD_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  com_bus_arbiter_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0]  PTR_RESET = PTR_W'(NUM_REQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {P_IDLE, P_GRANT, P_RELEASE} proc_state_t;
  typedef enum logic       {S_IDLE, S_GRANT} snoop_state_t;

  proc_state_t        p_state;
  snoop_state_t       s_state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [NUM_REQ-1:0] gnt_proc_q;
  logic [NUM_REQ-1:0] gnt_snoop_q;
  logic               mem_gnt_q;
  logic               busy_q;
  logic               err_q;

  logic               rr_found;
  logic [PTR_W-1:0]   rr_winner;
  logic               sn_found;
  logic [PTR_W-1:0]   sn_winner;
  logic               proc_held;
  logic               snoop_held;

  // Round-robin pick: first set request scanning upward from the slot after
  // the last winner, wrapping modulo NUM_REQ, so the previous owner is
  // considered last.
  always_comb begin
    int               cand;
    logic [PTR_W-1:0] cand_idx;
    rr_found  = 1'b0;
    rr_winner = rr_ptr;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(rr_ptr) + k) % NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!rr_found && bus.Com_Bus_Req_proc[cand_idx]) begin
        rr_found  = 1'b1;
        rr_winner = cand_idx;
      end
    end
  end

  // Fixed-priority snoop pick: scanning from the top down leaves the lowest
  // set index as the winner. Memory is only considered when no snoop
  // requester is asking.
  always_comb begin
    sn_found  = 1'b0;
    sn_winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.Com_Bus_Req_snoop[i]) begin
        sn_found  = 1'b1;
        sn_winner = PTR_W'(i);
      end
    end
  end

  // An owner keeps its grant only while its own request bit stays high;
  // requests on other indices never affect a held grant.
  always_comb begin
    proc_held  = |(bus.Com_Bus_Req_proc & gnt_proc_q);
    snoop_held = (|(bus.Com_Bus_Req_snoop & gnt_snoop_q)) |
                 (mem_gnt_q & bus.Mem_snoop_req);
  end

  // Proc-domain FSM. The hold counter is loaded with 1 on the grant edge so
  // it equals the number of cycles the grant has been visible; Arb_err rises
  // on the edge it reaches MAX_HOLD. After a release the bus sits in
  // P_RELEASE for at least one dead cycle, and longer if a snoop transfer
  // started under this owner is still running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state    <= P_IDLE;
      rr_ptr     <= PTR_RESET;
      hold_cnt   <= '0;
      gnt_proc_q <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      unique case (p_state)
        P_IDLE: begin
          if (rr_found) begin
            gnt_proc_q <= NUM_REQ'(1) << rr_winner;
            rr_ptr     <= rr_winner;
            hold_cnt   <= HOLD_ONE;
            busy_q     <= 1'b1;
            p_state    <= P_GRANT;
          end
        end
        P_GRANT: begin
          if (proc_held) begin
            if (hold_cnt < HOLD_MAX) begin
              hold_cnt <= hold_cnt + HOLD_ONE;
            end
            if (hold_cnt == HOLD_MAX - HOLD_ONE) begin
              err_q <= 1'b1;
            end
          end else begin
            gnt_proc_q <= '0;
            hold_cnt   <= '0;
            p_state    <= P_RELEASE;
          end
        end
        P_RELEASE: begin
          if (s_state == S_IDLE) begin
            busy_q  <= 1'b0;
            p_state <= P_IDLE;
          end
        end
        default: begin
          p_state <= P_IDLE;
        end
      endcase
    end
  end

  // Snoop-domain FSM. New snoop grants are only issued while a proc owner is
  // in P_GRANT, but an active snoop grant runs to completion even if the
  // proc side releases underneath it. Returning to S_IDLE costs one dead
  // cycle before the next snoop grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_state     <= S_IDLE;
      gnt_snoop_q <= '0;
      mem_gnt_q   <= 1'b0;
    end else begin
      unique case (s_state)
        S_IDLE: begin
          if (p_state == P_GRANT) begin
            if (sn_found) begin
              gnt_snoop_q <= NUM_REQ'(1) << sn_winner;
              s_state     <= S_GRANT;
            end else if (bus.Mem_snoop_req) begin
              mem_gnt_q <= 1'b1;
              s_state   <= S_GRANT;
            end
          end
        end
        S_GRANT: begin
          if (!snoop_held) begin
            gnt_snoop_q <= '0;
            mem_gnt_q   <= 1'b0;
            s_state     <= S_IDLE;
          end
        end
        default: begin
          s_state <= S_IDLE;
        end
      endcase
    end
  end

  // All outputs come straight from registers.
  assign bus.Com_Bus_Gnt_proc  = gnt_proc_q;
  assign bus.Com_Bus_Gnt_snoop = gnt_snoop_q;
  assign bus.Mem_snoop_gnt     = mem_gnt_q;
  assign bus.Bus_busy          = busy_q;
  assign bus.Arb_err           = err_q;

endmodule

// File: tb/tb_com_bus_arbiter.sv
// tb_com_bus_arbiter
// Self-checking bench for com_bus_arbiter. Directed scenarios compare the
// outputs against hand-derived constants; a randomized run compares them
// every cycle against a behavioural model that tracks owner indices,
// a dead-cycle flag and a hold count.
// Ports: none (top-level bench).
module tb_com_bus_arbiter;

  localparam int N    = 8;
  localparam int HOLD = 8;
  localparam int OW   = 2 * N + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Model state: proc owner (-1 none), last winner, cycles held, dead-cycle
  // flag, snoop owner (-1 none, N = memory) and sticky error.
  int m_owner;
  int m_last;
  int m_hold;
  int m_snp;
  bit m_dead;
  bit m_err;

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  com_bus_arbiter_if #(.NUM_REQ(N)) bus ();

  com_bus_arbiter #(
    .NUM_REQ (N),
    .MAX_HOLD(HOLD),
    .HOLD_W  (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  function automatic logic [OW-1:0] pack(logic [N-1:0] gp, logic [N-1:0] gs,
                                         logic mg, logic busy, logic err);
    return {gp, gs, mg, busy, err};
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {bus.Com_Bus_Gnt_proc, bus.Com_Bus_Gnt_snoop, bus.Mem_snoop_gnt,
            bus.Bus_busy, bus.Arb_err};
  endfunction

  function automatic logic [OW-1:0] model_out();
    logic [N-1:0] gp;
    logic [N-1:0] gs;
    gp = '0;
    gs = '0;
    if (m_owner >= 0) gp[m_owner[2:0]] = 1'b1;
    if (m_snp >= 0 && m_snp < N) gs[m_snp[2:0]] = 1'b1;
    return {gp, gs, m_snp == N, (m_owner >= 0) || m_dead, m_err};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_hold  = 0;
    m_snp   = -1;
    m_dead  = 1'b0;
    m_err   = 1'b0;
  endtask

  // Advance the model by one clock edge using the request levels present at
  // that edge.
  task automatic model_step();
    int           n_owner;
    int           n_last;
    int           n_hold;
    int           n_snp;
    bit           n_dead;
    bit           n_err;
    int           idx;
    logic [N-1:0] rp;
    logic [N-1:0] rs;
    logic         rm;
    n_owner = m_owner;
    n_last  = m_last;
    n_hold  = m_hold;
    n_snp   = m_snp;
    n_dead  = m_dead;
    n_err   = m_err;
    rp = bus.Com_Bus_Req_proc;
    rs = bus.Com_Bus_Req_snoop;
    rm = bus.Mem_snoop_req;
    if (m_owner >= 0) begin
      if (rp[m_owner[2:0]]) begin
        if (m_hold < HOLD) n_hold = m_hold + 1;
        if (n_hold == HOLD) n_err = 1'b1;
      end else begin
        n_owner = -1;
        n_hold  = 0;
        n_dead  = 1'b1;
      end
    end else if (m_dead) begin
      if (m_snp < 0) n_dead = 1'b0;
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (n_owner < 0 && rp[idx[2:0]]) begin
          n_owner = idx;
          n_last  = idx;
          n_hold  = 1;
        end
      end
    end
    if (m_snp >= 0) begin
      if (m_snp == N) begin
        if (!rm) n_snp = -1;
      end else if (!rs[m_snp[2:0]]) begin
        n_snp = -1;
      end
    end else if (m_owner >= 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (rs[i[2:0]]) n_snp = i;
      end
      if (n_snp < 0 && rm) n_snp = N;
    end
    m_owner = n_owner;
    m_last  = n_last;
    m_hold  = n_hold;
    m_snp   = n_snp;
    m_dead  = n_dead;
    m_err   = n_err;
  endtask

  // One clock edge; outputs are then observed 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.Com_Bus_Req_proc  = '0;
    bus.Com_Bus_Req_snoop = '0;
    bus.Mem_snoop_req     = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [OW-1:0] exp;
    do_reset();
    exp = pack(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dut_out() !== exp) begin
      errors++;
      $display("[TB] FAIL reset_values: got %h expected %h", dut_out(), exp);
    end
    bus.Com_Bus_Req_proc = 8'hFF;
    tick();
    exp = pack(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dut_out() !== exp) begin
      errors++;
      $display("[TB] FAIL first_grant: got %h expected %h", dut_out(), exp);
    end
  endtask

  task automatic test_round_robin();
    logic [OW-1:0] exp;
    logic [N-1:0]  gp;
    int            who;
    do_reset();
    bus.Com_Bus_Req_proc = 8'hFF;
    for (int i = 0; i <= N; i++) begin
      who = i % N;
      gp  = '0;
      gp[who[2:0]] = 1'b1;
      for (int c = 0; c < 3; c++) begin
        tick();
        exp = pack(gp, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++;
        if (dut_out() !== exp) begin
          errors++;
          $display("[TB] FAIL rr_grant[%0d]: got %h expected %h", i, dut_out(), exp);
        end
      end
      bus.Com_Bus_Req_proc[who[2:0]] = 1'b0;
      tick();
      exp = pack(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
      checks++;
      if (dut_out() !== exp) begin
        errors++;
        $display("[TB] FAIL rr_release[%0d]: got %h expected %h", i, dut_out(), exp);
      end
      bus.Com_Bus_Req_proc[who[2:0]] = 1'b1;
      tick();
      exp = pack(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++;
      if (dut_out() !== exp) begin
        errors++;
        $display("[TB] FAIL rr_idle[%0d]: got %h expected %h", i, dut_out(), exp);
      end
    end
  endtask

  task automatic test_wraparound();
    logic [OW-1:0] exp;
    do_reset();
    bus.Com_Bus_Req_proc = 8'h81;
    tick();
    exp = pack(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dut_out() !== exp) begin
      errors++;
      $display("[TB] FAIL wrap_7_to_0: got %h expected %h", dut_out(), exp);
    end
    do_reset();
    bus.Com_Bus_Req_proc = 8'h08;
    tick();
    bus.Com_Bus_Req_proc = 8'h02;
    tick();
    bus.Com_Bus_Req_proc = 8'h0A;
    tick();
    tick();
    exp = pack(8'h02, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dut_out() !== exp) begin
      errors++;
      $display("[TB] FAIL strict_rotation: got %h expected %h", dut_out(), exp);
    end
  endtask

  task automatic test_snoop_priority();
    logic [OW-1:0] exp[9];
    do_reset();
    bus.Com_Bus_Req_snoop = 8'h0C;
    bus.Mem_snoop_req     = 1'b1;
    exp[0] = pack(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    exp[1] = pack(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    exp[2] = pack(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    exp[3] = pack(8'h01, 8'h04, 1'b0, 1'b1, 1'b0);
    exp[4] = pack(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    exp[5] = pack(8'h01, 8'h08, 1'b0, 1'b1, 1'b0);
    exp[6] = pack(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    exp[7] = pack(8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    exp[8] = pack(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int s = 0; s < 9; s++) begin
      if (s == 2) bus.Com_Bus_Req_proc  = 8'h01;
      if (s == 4) bus.Com_Bus_Req_snoop = 8'h08;
      if (s == 6) bus.Com_Bus_Req_snoop = 8'h00;
      if (s == 8) bus.Mem_snoop_req     = 1'b0;
      tick();
      checks++;
      if (dut_out() !== exp[s]) begin
        errors++;
        $display("[TB] FAIL snoop_step[%0d]: got %h expected %h", s, dut_out(), exp[s]);
      end
    end
  endtask

  task automatic test_proc_waits_snoop();
    logic [OW-1:0] exp[9];
    do_reset();
    bus.Com_Bus_Req_proc  = 8'h01;
    bus.Com_Bus_Req_snoop = 8'h20;
    exp[0] = pack(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    exp[1] = pack(8'h01, 8'h20, 1'b0, 1'b1, 1'b0);
    exp[2] = pack(8'h00, 8'h20, 1'b0, 1'b1, 1'b0);
    exp[3] = pack(8'h00, 8'h20, 1'b0, 1'b1, 1'b0);
    exp[4] = pack(8'h00, 8'h20, 1'b0, 1'b1, 1'b0);
    exp[5] = pack(8'h00, 8'h20, 1'b0, 1'b1, 1'b0);
    exp[6] = pack(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    exp[7] = pack(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    exp[8] = pack(8'h02, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int s = 0; s < 9; s++) begin
      if (s == 2) bus.Com_Bus_Req_proc  = 8'h02;
      if (s == 6) bus.Com_Bus_Req_snoop = 8'h00;
      tick();
      checks++;
      if (dut_out() !== exp[s]) begin
        errors++;
        $display("[TB] FAIL proc_wait[%0d]: got %h expected %h", s, dut_out(), exp[s]);
      end
    end
  endtask

  task automatic test_hold_watchdog();
    logic [OW-1:0] exp;
    do_reset();
    bus.Com_Bus_Req_proc = 8'h01;
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp = pack(8'h01, 8'h00, 1'b0, 1'b1, c >= HOLD);
      checks++;
      if (dut_out() !== exp) begin
        errors++;
        $display("[TB] FAIL watchdog_cycle[%0d]: got %h expected %h", c, dut_out(), exp);
      end
    end
    bus.Com_Bus_Req_proc = 8'h00;
    tick();
    tick();
    exp = pack(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if (dut_out() !== exp) begin
      errors++;
      $display("[TB] FAIL watchdog_sticky: got %h expected %h", dut_out(), exp);
    end
  endtask

  task automatic test_async_reset();
    logic [OW-1:0] exp;
    do_reset();
    bus.Com_Bus_Req_proc = 8'h10;
    bus.Mem_snoop_req    = 1'b1;
    tick();
    tick();
    exp = pack(8'h10, 8'h00, 1'b1, 1'b1, 1'b0);
    checks++;
    if (dut_out() !== exp) begin
      errors++;
      $display("[TB] FAIL pre_reset_state: got %h expected %h", dut_out(), exp);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp = pack(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dut_out() !== exp) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h expected %h", dut_out(), exp);
    end
    model_reset();
    bus.Com_Bus_Req_proc = 8'h90;
    bus.Mem_snoop_req    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    exp = pack(8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dut_out() !== exp) begin
      errors++;
      $display("[TB] FAIL post_reset_grant: got %h expected %h", dut_out(), exp);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] rp;
    logic [N-1:0] rs;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rp = bus.Com_Bus_Req_proc;
      rs = bus.Com_Bus_Req_snoop;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) rp[i[2:0]] = ~rp[i[2:0]];
        if ($urandom_range(0, 5) == 0) rs[i[2:0]] = ~rs[i[2:0]];
      end
      bus.Com_Bus_Req_proc  = rp;
      bus.Com_Bus_Req_snoop = rs;
      if ($urandom_range(0, 5) == 0) bus.Mem_snoop_req = ~bus.Mem_snoop_req;
      tick();
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("[TB] FAIL random_cycle[%0d]: got %h expected %h", cyc, dut_out(), model_out());
      end
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    bus.Com_Bus_Req_proc  = '0;
    bus.Com_Bus_Req_snoop = '0;
    bus.Mem_snoop_req     = 1'b0;
    model_reset();
    test_reset();
    test_round_robin();
    test_wraparound();
    test_snoop_priority();
    test_proc_waits_snoop();
    test_hold_watchdog();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
